reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares a single enable-gated register bank (D flip-flops with enable) among `NREQ` requesters. Each granted write is sequenced as exactly one `en_out` pulse carrying the selected requester's data, followed by a one-cycle `ack` to that requester. The block sits between the requesting control logic and the register bank's `en`/`d` inputs; it is the only driver of those inputs.

---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_rr_pick.sv | 36 +++
 rtl/reg_write_arbiter.sv | 131 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the round-robin register-bank write arbiter:
// FSM state encoding and the grant index width helper.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Index width for n requesters; never below one bit.
  function automatic int gid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_DEFAULT = 4;
  localparam int GID_W        = gid_w(NREQ_DEFAULT);

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after
// (ptr+1) mod NREQ wins.
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = gid_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic            valid,
  output logic [GW-1:0]   idx
);

  logic [GW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = GW'((int'(ptr) + gi + 1) % NREQ);
    end
  endgenerate

  // Walk from the farthest candidate back so the nearest one to ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of an enable-gated register bank.
// Optional burst mode (lock port, beat counter) under REG_WRITE_ARBITER_BURST_EN.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
`ifdef REG_WRITE_ARBITER_BURST_EN
  , parameter int BURST_MAX = 4
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
`ifdef REG_WRITE_ARBITER_BURST_EN
  input  logic [NREQ-1:0]         lock,
`endif
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic                    en_out,
  output logic [WIDTH-1:0]        d_out,
  output logic [NREQ-1:0]         ack,
  output logic [gid_w(NREQ)-1:0]  grant_id,
  output logic                    busy
);

  localparam int GW = gid_w(NREQ);

  state_t            state_reg, state_next;
  logic [GW-1:0]     gid_reg, gid_next;
  logic [GW-1:0]     ptr_reg, ptr_next;
  logic              en_reg;
  logic [WIDTH-1:0]  d_reg, d_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              busy_reg;
  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic [WIDTH-1:0]  wd [NREQ];
`ifdef REG_WRITE_ARBITER_BURST_EN
  logic [3:0]        cnt_reg, cnt_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wd
      assign wd[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    gid_next   = gid_reg;
    ptr_next   = ptr_reg;
`ifdef REG_WRITE_ARBITER_BURST_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = WRITE;
          gid_next   = pick_idx;
        end
      end
      WRITE: state_next = ACK;
      ACK: begin
`ifdef REG_WRITE_ARBITER_BURST_EN
        // Stay on the same grantee; ptr only moves once the burst is over.
        if (lock[gid_reg] && req[gid_reg] && (cnt_reg < 4'(BURST_MAX - 1))) begin
          state_next = WRITE;
          cnt_next   = cnt_reg + 4'd1;
        end else begin
          state_next = IDLE;
          ptr_next   = gid_reg;
          cnt_next   = '0;
        end
`else
        state_next = IDLE;
        ptr_next   = gid_reg;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  always_comb begin
    d_next   = d_reg;
    ack_next = '0;
    if (state_next == WRITE) d_next = wd[gid_next];
    if (state_next == ACK) ack_next[gid_next] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      gid_reg   <= '0;
      ptr_reg   <= GW'(NREQ - 1);
      en_reg    <= 1'b0;
      d_reg     <= '0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
`ifdef REG_WRITE_ARBITER_BURST_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      gid_reg   <= gid_next;
      ptr_reg   <= ptr_next;
      en_reg    <= (state_next == WRITE);
      d_reg     <= d_next;
      ack_reg   <= ack_next;
      busy_reg  <= (state_next != IDLE);
`ifdef REG_WRITE_ARBITER_BURST_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  assign en_out   = en_reg;
  assign d_out    = d_reg;
  assign ack      = ack_reg;
  assign grant_id = gid_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NREQ=4, WIDTH=8).
// Burst scenario is exercised only when REG_WRITE_ARBITER_BURST_EN is defined.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [31:0] wdata = '0;
  logic        en_out;
  logic [7:0]  d_out;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_en_cyc;
  bit en_seen;

  reg_write_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
`ifdef REG_WRITE_ARBITER_BURST_EN
    .lock     (lock),
`endif
    .wdata    (wdata),
    .en_out   (en_out),
    .d_out    (d_out),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Poll (bounded) for the next en_out pulse, then log the beat.
  task automatic wait_en(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (en_out) break;
      tick();
    end
    check({tag, "_en"}, en_out, 1);
    $display("[%0d] beat grant=%0d d_out=%02h", cyc, grant_id, d_out);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_en", en_out, 0);
    check("rst_d", d_out, 0);
    check("rst_ack", ack, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Single request from requester 2
    wdata[2*8 +: 8] = 8'hA5;
    req = 4'b0100;
    tick();
    check("t1_en", en_out, 1);
    check("t1_d", d_out, 8'hA5);
    check("t1_gid", grant_id, 2);
    check("t1_busy", busy, 1);
    check("t1_ack0", ack, 0);
    tick();
    check("t1_en_off", en_out, 0);
    check("t1_ack", ack, 4'b0100);
    req = 4'b0000;
    tick();
    check("t1_ack_off", ack, 0);
    check("t1_idle", busy, 0);

    // All four together after reset: order 0,1,2,3, 3 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_en("t2");
      check("t2_gid", grant_id, k);
      check("t2_d", d_out, 8'h10 + k);
      if (k > 0) check("t2_gap", cyc - last_en_cyc, 3);
      last_en_cyc = cyc;
      tick();
      check("t2_ack", ack, 4'b0001 << k);
      req[k] = 1'b0;
    end
    tick();

    // Fairness: requesters 0 and 1 continuous (ptr=3 after previous test)
    req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      wait_en("t3");
      check("t3_gid", grant_id, k % 2);
      tick();
      check("t3_ack", ack, 4'b0001 << (k % 2));
      if (k == 7) req = 4'b0000;
      tick();
    end
    tick();

    // Mid-operation reset during WRITE
    req = 4'b0010;
    tick();
    check("t4_en_pre", en_out, 1);
    #1 reset = 1'b0;
    #1;
    check("t4_en_rst", en_out, 0);
    check("t4_busy_rst", busy, 0);
    check("t4_ack_rst", ack, 0);
    req = 4'b0000;
    tick();
    check("t4_ack_hold", ack, 0);
    reset = 1'b1;
    tick();
    check("t4_idle", busy, 0);
    req = 4'b1001;
    wait_en("t4");
    check("t4_gid", grant_id, 0);
    tick();
    check("t4_ack", ack, 4'b0001);
    req = 4'b0000;
    tick();
    tick();

`ifdef REG_WRITE_ARBITER_BURST_EN
    // Burst: requester 3 locked with requester 0 waiting (ptr=0 now)
    wdata[3*8 +: 8] = 8'h77;
    req  = 4'b1001;
    lock = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      wait_en("t5");
      check("t5_gid", grant_id, 3);
      check("t5_d", d_out, 8'h77);
      if (k > 0) check("t5_gap", cyc - last_en_cyc, 2);
      last_en_cyc = cyc;
      tick();
      check("t5_ack", ack, 4'b1000);
      if (k == 3) begin
        req[3]  = 1'b0;
        lock[3] = 1'b0;
      end else begin
        tick();
      end
    end
    wait_en("t5_after");
    check("t5_next_gid", grant_id, 0);
    tick();
    check("t5_next_ack", ack, 4'b0001);
    req = 4'b0000;
    tick();
    tick();
`endif

    // Idle hold after a write of 8'h3C
    wdata[2*8 +: 8] = 8'h3C;
    req = 4'b0100;
    wait_en("t6");
    check("t6_d", d_out, 8'h3C);
    tick();
    req = 4'b0000;
    tick();
    en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t6_en", en_out, 0);
      check("t6_hold", d_out, 8'h3C);
      check("t6_busy", busy, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
